// File: rtl/eta_adder_pipe.sv
// Two-stage pipelined error-tolerant adder (ETA-I): carry-free approximate low part, exact high part.
// Optional ERR_STATS_EN adds saturating approximate-transaction and error counters.
module eta_adder_pipe #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned APPROX_MAX = 8,
  parameter int unsigned KW         = $clog2(APPROX_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  input  logic [KW-1:0]    in_k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef ERR_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [31:0]      txn_cnt,
  output logic [31:0]      err_cnt
`endif
);

  logic                  s1_v;
  logic [WIDTH-1:0]      s1_a;
  logic [WIDTH-1:0]      s1_b;
  logic [KW-1:0]         s1_k;
  logic [APPROX_MAX-1:0] s1_lo;
  logic [KW-1:0]         keff;
  logic [APPROX_MAX-1:0] lo_c;
  logic [WIDTH-1:0]      hi_mask;
  logic [WIDTH:0]        hi_sum;
  logic                  out_adv;

  // Output register can take new data when empty or being drained this cycle.
  assign out_adv  = !out_valid || out_ready;
  assign in_ready = !s1_v || out_adv;

  always_comb begin : keff_sel
    keff = '0;
    if (in_mode) begin
      keff = (in_k > KW'(APPROX_MAX)) ? KW'(APPROX_MAX) : in_k;
    end
  end

  // Scan down from bit Keff-1; the first generate position saturates itself and everything below.
  always_comb begin : approx_lo
    logic found;
    found = 1'b0;
    lo_c  = '0;
    for (int i = int'(APPROX_MAX) - 1; i >= 0; i--) begin
      if (32'(i) < 32'(keff)) begin
        if (found || (in_a[i] && in_b[i])) begin
          lo_c[i] = 1'b1;
          found   = 1'b1;
        end else begin
          lo_c[i] = in_a[i] ^ in_b[i];
        end
      end
    end
  end

  // Low bits are masked off, so the high adder sees carry-in 0 from the approximate part.
  always_comb begin : hi_add
    hi_mask = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      hi_mask[i] = (32'(i) >= 32'(s1_k));
    end
    hi_sum = {1'b0, s1_a & hi_mask} + {1'b0, s1_b & hi_mask};
  end

  always_ff @(posedge clk or posedge rst) begin : s1_reg
    if (rst) begin
      s1_v  <= 1'b0;
      s1_a  <= '0;
      s1_b  <= '0;
      s1_k  <= '0;
      s1_lo <= '0;
    end else if (in_ready) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_a  <= in_a;
        s1_b  <= in_b;
        s1_k  <= keff;
        s1_lo <= lo_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin : out_reg
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
    end else if (out_adv) begin
      out_valid <= s1_v;
      if (s1_v) begin
        out_sum  <= hi_sum[WIDTH-1:0] | WIDTH'(s1_lo);
        out_cout <= hi_sum[WIDTH];
      end
    end
  end

`ifdef ERR_STATS_EN
  logic           s1_mode;
  logic           out_mode;
  logic [WIDTH:0] out_ref;

  // Exact reference and mode ride alongside the datapath to the output register.
  always_ff @(posedge clk or posedge rst) begin : stats_pipe
    if (rst) begin
      s1_mode  <= 1'b0;
      out_mode <= 1'b0;
      out_ref  <= '0;
    end else begin
      if (in_ready && in_valid) begin
        s1_mode <= in_mode;
      end
      if (out_adv && s1_v) begin
        out_mode <= s1_mode;
        out_ref  <= {1'b0, s1_a} + {1'b0, s1_b};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin : stats_cnt
    if (rst) begin
      txn_cnt <= '0;
      err_cnt <= '0;
    end else if (stats_clr) begin
      txn_cnt <= '0;
      err_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (out_mode && (txn_cnt != '1)) begin
        txn_cnt <= txn_cnt + 32'd1;
      end
      if (({out_cout, out_sum} != out_ref) && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_eta_adder_pipe.sv
// Directed, table-driven bench for eta_adder_pipe (WIDTH=16, APPROX_MAX=8).
module tb_eta_adder_pipe;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        mode;
    logic [3:0]  k;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_mode;
  logic [3:0]  in_k;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
`ifdef ERR_STATS_EN
  logic        stats_clr;
  logic [31:0] txn_cnt;
  logic [31:0] err_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  eta_adder_pipe #(.WIDTH(16), .APPROX_MAX(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .in_k      (in_k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef ERR_STATS_EN
    ,
    .stats_clr (stats_clr),
    .txn_cnt   (txn_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_a    = v.a;
    in_b    = v.b;
    in_mode = v.mode;
    in_k    = v.k;
  endtask

  // Single isolated transaction: check ready, exact 2-cycle latency and result.
  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    chk($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    drive(v);
    @(negedge clk);
    in_valid = 1'b0;
    chk($sformatf("v%0d_lat1_valid", idx), 32'(out_valid), 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_lat2_valid", idx), 32'(out_valid), 32'd1);
    chk($sformatf("v%0d_sum", idx), 32'(out_sum), 32'(v.sum));
    chk($sformatf("v%0d_cout", idx), 32'(out_cout), 32'(v.cout));
  endtask

  vec_t        tbl [11];
  vec_t        bp  [6];
  logic [3:0]  pat = 4'b1001;

  initial begin
    int   sent;
    int   got;
    logic held_v;
    logic [16:0] held;

    //            a          b          mode  k      sum        cout
    tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, 4'd0,  16'h0000, 1'b1};
    tbl[1]  = '{16'h00F0, 16'h0010, 1'b1, 4'd8,  16'h00FF, 1'b0};
    tbl[2]  = '{16'h1234, 16'h4321, 1'b1, 4'd8,  16'h553F, 1'b0};
    tbl[3]  = '{16'hFFFF, 16'h0001, 1'b1, 4'd8,  16'hFFFF, 1'b0};
    tbl[4]  = '{16'h1234, 16'h4321, 1'b1, 4'd15, 16'h553F, 1'b0};
    tbl[5]  = '{16'h1234, 16'h4321, 1'b1, 4'd0,  16'h5555, 1'b0};
    tbl[6]  = '{16'h1234, 16'h4321, 1'b0, 4'd8,  16'h5555, 1'b0};
    tbl[7]  = '{16'h00FF, 16'h0001, 1'b1, 4'd4,  16'h00FF, 1'b0};
    tbl[8]  = '{16'h0003, 16'h0001, 1'b1, 4'd1,  16'h0003, 1'b0};
    tbl[9]  = '{16'h8000, 16'h8000, 1'b1, 4'd8,  16'h0000, 1'b1};
    tbl[10] = '{16'h0005, 16'h0006, 1'b1, 4'd3,  16'h0007, 1'b0};

    bp[0] = tbl[0];
    bp[1] = tbl[2];
    bp[2] = tbl[6];
    bp[3] = tbl[9];
    bp[4] = tbl[5];
    bp[5] = tbl[7];

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive('0);
`ifdef ERR_STATS_EN
    stats_clr = 1'b0;
`endif

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_cout", 32'(out_cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      run_vec(tbl[i], i);
    end

    // Reset the cycle after accept: the transaction must vanish.
    @(negedge clk);
    in_valid = 1'b1;
    drive(tbl[2]);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("midrst_after%0d_valid", i), 32'(out_valid), 32'd0);
    end
    chk("midrst_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back mixed stream with out_ready pattern 1,0,0,1.
    sent   = 0;
    got    = 0;
    held_v = 1'b0;
    held   = '0;
    for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
      @(negedge clk);
      if (held_v) begin
        chk($sformatf("bp_hold%0d_valid", cyc), 32'(out_valid), 32'd1);
        chk($sformatf("bp_hold%0d_data", cyc), 32'({out_cout, out_sum}), 32'(held));
      end
      out_ready = pat[cyc % 4];
      if (sent < 6) begin
        in_valid = 1'b1;
        drive(bp[sent]);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        chk($sformatf("bp_out%0d", got), 32'({out_cout, out_sum}), 32'({bp[got].cout, bp[got].sum}));
        got++;
      end
      held_v = out_valid && !out_ready;
      held   = {out_cout, out_sum};
      if (in_valid && in_ready) sent++;
    end
    chk("bp_count", 32'(got), 32'd6);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_no_extra", 32'(out_valid), 32'd0);

`ifdef ERR_STATS_EN
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    run_vec(tbl[1], 101);
    run_vec(tbl[2], 102);
    run_vec(tbl[3], 103);
    run_vec(tbl[0], 104);
    @(negedge clk);
    chk("stats_txn", txn_cnt, 32'd3);
    chk("stats_err", err_cnt, 32'd3);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    chk("stats_clr_txn", txn_cnt, 32'd0);
    chk("stats_clr_err", err_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
